// File: rtl/mandel_run_ctrl.sv
// Run controller for the Mandelbrot core: launches runs, times them, queues {ret, cycles, timeout} results.
// Latency: start one cycle after command accept; result at FIFO head two cycles after core ready.
// Backpressure: a full result FIFO holds the FSM in PUSH, so no further start until the entry is written.
//
// Ports:
//   clk, reset (async, active-low)
//   cmd_valid/cmd_ready/cmd_runs : batch command from the host (cmd_runs = 0 runs once)
//   start/core_ready/core_ret/core_reset : handshake with the core
//   res_valid/res_ready/res_ret/res_cycles/res_timeout : result FIFO head and pop
//   busy, runs_done : status

// Generic single-clock FIFO, circular buffer with wrapping pointers and an occupancy count.
// Latency: a write is visible at the head on the next cycle when the FIFO was empty.
// Backpressure: writes are dropped while full (callers hold off); reads only when rd_vld.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             full,
    output logic             rd_vld,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat
);
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int AWP1 = AW + 1;
    localparam logic [AW:0] FULL_CNT = AWP1'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             do_wr;
    logic             do_rd;

    assign full   = (cnt_q == FULL_CNT);
    assign rd_vld = (cnt_q != '0);
    assign do_wr  = wr_vld && !full;
    assign do_rd  = rd_vld && rd_rdy;
    assign rd_dat = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_wr) begin
                mem_q[wr_ptr_q] <= wr_dat;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   cnt_q <= cnt_q + AWP1'(1);
                2'b01:   cnt_q <= cnt_q - AWP1'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

module mandel_run_ctrl #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd16777216,
    parameter int unsigned RECOVER_CYCLES = 4,
    parameter int unsigned RES_DEPTH      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_runs,
    output logic        start,
    input  logic        core_ready,
    input  logic [31:0] core_ret,
    output logic        core_reset,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_ret,
    output logic [31:0] res_cycles,
    output logic        res_timeout,
    output logic        busy,
    output logic [7:0]  runs_done
);
    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_PUSH, S_RECOVER} state_t;

    typedef struct packed {
        logic [31:0] ret;
        logic [31:0] cycles;
        logic        timeout;
    } res_t;

    localparam logic [31:0] REC_LAST = 32'(RECOVER_CYCLES - 1);

    state_t      state_q;
    state_t      state_d;
    logic [31:0] cnt_q;
    logic [31:0] rec_cnt_q;
    logic [7:0]  runs_left_q;
    logic [7:0]  runs_done_q;
    res_t        ent_q;
    res_t        head;
    logic        rst_hold_q;   // keeps core_reset high from reset until the first clock edge
    logic        fifo_full;
    logic        push;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (cmd_valid) state_d = S_LAUNCH;
            S_LAUNCH:  state_d = S_WAIT;   // core_ready may be stale here; never sampled
            S_WAIT:    if (core_ready || (cnt_q == TIMEOUT_CYCLES)) state_d = S_PUSH;
            S_PUSH: begin
                // Stall decision uses the occupancy at the start of the cycle; a
                // same-cycle pop frees the slot for the next cycle only.
                if (!fifo_full) begin
                    if (ent_q.timeout)            state_d = S_RECOVER;
                    else if (runs_left_q > 8'd1)  state_d = S_LAUNCH;
                    else                          state_d = S_IDLE;
                end
            end
            S_RECOVER: begin
                if (rec_cnt_q == REC_LAST) begin
                    state_d = (runs_left_q != 8'd0) ? S_LAUNCH : S_IDLE;
                end
            end
            default:   state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        cmd_ready  = 1'b0;
        start      = 1'b0;
        busy       = 1'b1;
        push       = 1'b0;
        core_reset = rst_hold_q;
        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            S_LAUNCH:  start      = 1'b1;
            S_PUSH:    push       = !fifo_full;
            S_RECOVER: core_reset = 1'b1;
            default:   ;
        endcase
    end

    // Datapath: run bookkeeping, cycle counter, pending entry, recover timer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q       <= '0;
            rec_cnt_q   <= '0;
            runs_left_q <= '0;
            runs_done_q <= '0;
            ent_q       <= '0;
            rst_hold_q  <= 1'b1;
        end else begin
            rst_hold_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        runs_left_q <= (cmd_runs == 8'd0) ? 8'd1 : cmd_runs;
                        runs_done_q <= '0;
                    end
                end
                S_LAUNCH: cnt_q <= 32'd1;
                S_WAIT: begin
                    if (cnt_q != '1) cnt_q <= cnt_q + 32'd1;
                    // Ready wins over the watchdog when both land on the same cycle.
                    if (core_ready) begin
                        ent_q <= {core_ret, cnt_q, 1'b0};
                    end else if (cnt_q == TIMEOUT_CYCLES) begin
                        ent_q <= {32'd0, TIMEOUT_CYCLES, 1'b1};
                    end
                end
                S_PUSH: begin
                    if (push) begin
                        runs_done_q <= runs_done_q + 8'd1;
                        runs_left_q <= runs_left_q - 8'd1;
                        rec_cnt_q   <= '0;
                    end
                end
                S_RECOVER: rec_cnt_q <= rec_cnt_q + 32'd1;
                default: ;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH ($bits(res_t)),
        .DEPTH (int'(RES_DEPTH))
    ) u_res_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_vld (push),
        .wr_dat (ent_q),
        .full   (fifo_full),
        .rd_vld (res_valid),
        .rd_rdy (res_ready),
        .rd_dat (head)
    );

    assign res_ret     = head.ret;
    assign res_cycles  = head.cycles;
    assign res_timeout = head.timeout;
    assign runs_done   = runs_done_q;
endmodule

// File: tb/tb_mandel_run_ctrl.sv
// Bench for mandel_run_ctrl: table vectors, hand sequences for stall/stale/reset, randomized batches.
// Latency: core model raises ready a planned number of cycles after each start.
// Backpressure: consumer ready is held low, high, or randomized per phase.
module tb_mandel_run_ctrl;
    localparam logic [31:0] TO    = 32'd20;
    localparam int          RC    = 4;
    localparam int          DEPTH = 4;

    typedef struct packed {
        logic [31:0] ret;
        logic [31:0] cyc;
        logic        to;
    } ent_t;

    typedef struct {
        int          runs;
        int          lat;
        logic [31:0] ret;
        ent_t        exp;
        int          exp_done;
        int          exp_rst;
        int          exp_gap;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_runs;
    logic        start;
    logic        core_ready;
    logic [31:0] core_ret;
    logic        core_reset;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_ret;
    logic [31:0] res_cycles;
    logic        res_timeout;
    logic        busy;
    logic [7:0]  runs_done;

    mandel_run_ctrl #(
        .TIMEOUT_CYCLES (TO),
        .RECOVER_CYCLES (RC),
        .RES_DEPTH      (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_runs    (cmd_runs),
        .start       (start),
        .core_ready  (core_ready),
        .core_ret    (core_ret),
        .core_reset  (core_reset),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_ret     (res_ret),
        .res_cycles  (res_cycles),
        .res_timeout (res_timeout),
        .busy        (busy),
        .runs_done   (runs_done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Run plan consumed by the core model, one record per start pulse.
    int          lat_a [512];
    logic [31:0] ret_a [512];
    int          plan_n = 0;
    bit          stale_req = 1'b0;

    // Observations
    int   cyc = 0;
    int   n_start = 0;
    int   n_crst = 0;
    int   start_t[$];
    ent_t got_q[$];
    int   got_idx = 0;
    ent_t exp_q[$];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Reference: a run answered within the watchdog window reports its own latency,
    // anything slower reports a timeout of exactly TO cycles.
    function automatic ent_t model(input int lat, input logic [31:0] ret);
        ent_t e;
        if (lat <= int'(TO)) e = {ret, 32'(lat), 1'b0};
        else                 e = {32'd0, TO, 1'b1};
        return e;
    endfunction

    task automatic plan(input int lat, input logic [31:0] ret);
        lat_a[plan_n] = lat;
        ret_a[plan_n] = ret;
        plan_n++;
    endtask

    // Core model
    int          k = 0;
    int          cur_lat = 0;
    logic [31:0] cur_ret = '0;
    int          drv_i = 0;
    bit          pend = 1'b0;
    initial begin
        core_ready = 1'b0;
        core_ret   = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                pend = 1'b0; core_ready = 1'b0; drv_i = plan_n;
            end else if (core_reset) begin
                pend = 1'b0; core_ready = 1'b0;
            end else if (start) begin
                core_ready = stale_req;
                k = 0;
                pend = (drv_i < plan_n);
                if (pend) begin
                    cur_lat = lat_a[drv_i];
                    cur_ret = ret_a[drv_i];
                    drv_i++;
                end
            end else begin
                core_ready = stale_req && !busy;
                if (pend) begin
                    k++;
                    if (k == cur_lat) begin
                        core_ready = 1'b1;
                        core_ret   = cur_ret;
                        pend       = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                if (start) begin
                    n_start++;
                    start_t.push_back(cyc);
                end
                if (core_reset) n_crst++;
                if (res_valid && res_ready) got_q.push_back({res_ret, res_cycles, res_timeout});
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic issue(input logic [7:0] runs, input string name);
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_runs  = runs;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk({name, "_start_after_accept"}, {start, cmd_ready, busy}, 3'b101);
    endtask

    task automatic wait_done(input bit rand_pop);
        int t;
        t = 0;
        do begin
            @(posedge clk); #1;
            if (rand_pop) res_ready = 1'($urandom_range(0, 1));
            t++;
        end while ((busy || res_valid) && t < 3000);
        chk("batch_within_budget", (t < 3000), 1'b1);
    endtask

    task automatic chk_results(input string name);
        ent_t e;
        chk({name, "_count"}, got_q.size() - got_idx, exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (got_idx < got_q.size()) begin
                chk({name, "_entry"}, got_q[got_idx], e);
                got_idx++;
            end
        end
        got_idx = got_q.size();
    endtask

    vec_t tbl [5];

    initial begin
        int s0;
        int r0;
        int nr;
        int nto;
        int lat;
        int t;
        logic [31:0] ret;

        tbl[0] = '{1, 10,   32'h0000_00FF, {32'h0000_00FF, 32'd10, 1'b0}, 1, 0, 0};
        tbl[1] = '{0, 1,    32'h1234_5678, {32'h1234_5678, 32'd1,  1'b0}, 1, 0, 0};
        tbl[2] = '{3, 20,   32'hA5A5_0003, {32'hA5A5_0003, 32'd20, 1'b0}, 3, 0, 22};
        tbl[3] = '{2, 1000, 32'h0000_DEAD, {32'd0,         32'd20, 1'b1}, 2, 8, 26};
        tbl[4] = '{4, 2,    32'h0000_0042, {32'h0000_0042, 32'd2,  1'b0}, 4, 0, 4};

        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_runs  = '0;
        res_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_ctrl", {start, res_valid, busy, runs_done, core_reset}, {1'b0, 1'b0, 1'b0, 8'd0, 1'b1});
        chk("reset_res_fields", {res_ret, res_cycles, res_timeout}, 65'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("core_reset_held_until_edge", core_reset, 1'b1);
        @(posedge clk); #1;
        chk("after_release", {core_reset, cmd_ready, busy}, 3'b010);

        // Table vectors: one latency per batch, free-running consumer
        for (int v = 0; v < 5; v++) begin
            nr = (tbl[v].runs == 0) ? 1 : tbl[v].runs;
            for (int i = 0; i < nr; i++) begin
                plan(tbl[v].lat, tbl[v].ret);
                exp_q.push_back(tbl[v].exp);
            end
            s0 = n_start;
            r0 = n_crst;
            issue(8'(tbl[v].runs), "tbl");
            wait_done(1'b0);
            chk_results("tbl");
            chk("tbl_runs_done", runs_done, 8'(tbl[v].exp_done));
            chk("tbl_starts", n_start - s0, tbl[v].exp_done);
            chk("tbl_core_reset_cycles", n_crst - r0, tbl[v].exp_rst);
            if (tbl[v].exp_gap != 0)
                chk("tbl_start_gap", start_t[start_t.size()-1] - start_t[start_t.size()-2], tbl[v].exp_gap);
        end

        // Backpressure: 6 runs into a 4-deep FIFO with no consumer
        res_ready = 1'b0;
        s0 = n_start;
        for (int i = 0; i < 6; i++) begin
            plan(3, 32'h100 + 32'(i));
            exp_q.push_back({32'h100 + 32'(i), 32'd3, 1'b0});
        end
        issue(8'd6, "bp");
        repeat (40) @(posedge clk);
        #1;
        chk("bp_starts_stalled", n_start - s0, 5);
        chk("bp_stalled_state", {busy, res_valid, runs_done}, {1'b1, 1'b1, 8'd4});
        cmd_valid = 1'b1;
        cmd_runs  = 8'd3;
        repeat (3) @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("bp_cmd_ignored_when_busy", n_start - s0, 5);
        res_ready = 1'b1;
        wait_done(1'b0);
        chk_results("bp");
        chk("bp_runs_done", runs_done, 8'd6);
        chk("bp_starts_total", n_start - s0, 6);

        // Stale ready held through LAUNCH, reasserted 5 cycles after release
        stale_req = 1'b1;
        plan(6, 32'h0000_005A);
        exp_q.push_back({32'h0000_005A, 32'd6, 1'b0});
        issue(8'd1, "stale");
        wait_done(1'b0);
        stale_req = 1'b0;
        chk_results("stale");

        // Reset during run 2 of 3
        s0 = n_start;
        for (int i = 0; i < 3; i++) plan(8, 32'h300 + 32'(i));
        exp_q.push_back({32'h300, 32'd8, 1'b0});
        issue(8'd3, "rst");
        t = 0;
        while ((n_start - s0) < 2 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        chk("rst_reached_run2", n_start - s0, 2);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_async_outputs", {start, res_valid, core_reset, busy, runs_done},
            {1'b0, 1'b0, 1'b1, 1'b0, 8'd0});
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_after_release", {cmd_ready, busy, core_reset, res_valid, runs_done},
            {1'b1, 1'b0, 1'b0, 1'b0, 8'd0});
        chk_results("rst");

        // Randomized batches with a random consumer
        for (int c = 0; c < 6; c++) begin
            nr  = $urandom_range(1, 6);
            nto = 0;
            for (int i = 0; i < nr; i++) begin
                lat = $urandom_range(1, 24);
                ret = $urandom;
                plan(lat, ret);
                exp_q.push_back(model(lat, ret));
                if (lat > int'(TO)) nto++;
            end
            s0 = n_start;
            r0 = n_crst;
            issue(8'(nr), "rand");
            wait_done(1'b1);
            res_ready = 1'b1;
            chk_results("rand");
            chk("rand_runs_done", runs_done, 8'(nr));
            chk("rand_starts", n_start - s0, nr);
            chk("rand_core_reset_cycles", n_crst - r0, nto * RC);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
